// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sharing of one 8-bit combinational ALU between NUM_REQ requesters.
// Optional feature macro: ALU_SCHED_OPCHECK_EN flags opcodes 3'b101..3'b111 as illegal,
// skips the ALU cycle for them and answers with data 0x00 and rsp_err=1.
module alu_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_opcode,
  input  logic [7:0]           alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 busy
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || ID_W != $clog2(NUM_REQ)) begin : g_bad_cfg
    $error("alu_scheduler: NUM_REQ must be 2..4 and ID_W must equal clog2(NUM_REQ)");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q;
  logic [ID_W-1:0] last_q;
  logic            err_q;
  logic [ID_W-1:0] grant_d;
  logic [ID_W-1:0] idx_d;
  logic            found_d;
  logic [7:0]      sel_a_d;
  logic [7:0]      sel_b_d;
  logic [2:0]      sel_op_d;
  logic            illegal_d;

  // round-robin search starting just after the last granted requester
  always_comb begin
    grant_d = last_q;
    idx_d   = last_q;
    found_d = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_d = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!found_d && req_valid[idx_d]) begin
        grant_d = idx_d;
        found_d = 1'b1;
      end
    end
  end

  // operand/opcode mux for the current winner
  always_comb begin
    sel_a_d  = '0;
    sel_b_d  = '0;
    sel_op_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_d == ID_W'(i)) begin
        sel_a_d  = req_a[8*i +: 8];
        sel_b_d  = req_b[8*i +: 8];
        sel_op_d = req_op[3*i +: 3];
      end
    end
  end

`ifdef ALU_SCHED_OPCHECK_EN
  assign illegal_d = sel_op_d[2] & |sel_op_d[1:0];
`else
  assign illegal_d = 1'b0;
`endif

  assign req_ready = (state_q == IDLE && found_d) ? NUM_REQ'(1) << grant_d : '0;
  assign busy      = state_q != IDLE;
  assign rsp_err   = err_q;

  // scheduler FSM: accept in IDLE, one ALU cycle in EXEC, hold response in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      err_q      <= 1'b0;
      last_q     <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state_q)
        IDLE: if (found_d) begin
          alu_a      <= sel_a_d;
          alu_b      <= sel_b_d;
          alu_opcode <= sel_op_d;
          rsp_id     <= grant_d;
          last_q     <= grant_d;
          err_q      <= illegal_d;
          if (illegal_d) begin
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            state_q   <= RESP;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result;
          rsp_valid <= 1'b1;
          state_q   <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: random and directed stimulus against a transaction-level model of the scheduler.
module tb_alu_scheduler;

  localparam int N  = 3;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic [3*N-1:0] req_op = '0;
  logic [7:0]     alu_a, alu_b, alu_result, rsp_data;
  logic [2:0]     alu_opcode;
  logic           rsp_valid, rsp_err, busy;
  logic           rsp_ready = 1'b0;
  logic [IW-1:0]  rsp_id;

  int checks = 0;
  int errors = 0;

  bit         pv[N];
  logic [7:0] pa[N], pb[N];
  logic [2:0] po[N];
  bit         rnd = 1'b0;
  bit         rdy = 1'b1;

  int         m_phase, m_last, m_id;
  logic [7:0] m_a, m_b, m_data;
  logic [2:0] m_op;
  logic       m_err;
  int         grants[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ~a;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_a, alu_b);

  alu_scheduler #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_id", rsp_id, 0);
    check("rst_data", rsp_data, 0);
    check("rst_err", rsp_err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_opcode, 0);
    m_phase = 0; m_last = N - 1; m_id = 0; m_data = 0; m_err = 0;
    m_a = 0; m_b = 0; m_op = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic step();
    int w;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pa[i] = 8'($urandom);
          pb[i] = 8'($urandom);
          po[i] = 3'($urandom_range(0, 7));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      rsp_ready = rdy;
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = pv[i];
      req_a[8*i +: 8]   = pa[i];
      req_b[8*i +: 8]   = pb[i];
      req_op[3*i +: 3]  = po[i];
    end
    #1;
    w = -1;
    if (m_phase == 0)
      for (int k = 1; k <= N; k++)
        if (w < 0 && pv[(m_last + k) % N]) w = (m_last + k) % N;
    check("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
    check("busy", busy, m_phase != 0);
    check("rsp_valid", rsp_valid, m_phase == 2);
    check("rsp_id", rsp_id, m_id);
    check("rsp_data", rsp_data, m_data);
    check("rsp_err", rsp_err, m_err);
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_opcode", alu_opcode, m_op);
    if (m_phase == 2 && rsp_ready) begin
      grants.push_back(m_id);
      m_phase = 0;
    end else if (m_phase == 1) begin
      m_data  = alu_f(m_op, m_a, m_b);
      m_phase = 2;
    end else if (w >= 0) begin
      m_id = w; m_last = w; m_a = pa[w]; m_b = pb[w]; m_op = po[w];
      pv[w] = 1'b0;
      m_err = 1'b0;
      m_phase = 1;
`ifdef ALU_SCHED_OPCHECK_EN
      if (m_op >= 3'd5) begin
        m_err = 1'b1;
        m_data = 8'h00;
        m_phase = 2;
      end
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; pa[i] = '0; pb[i] = '0; po[i] = '0;
    end
    @(negedge clk);
    do_reset();
    pv[0] = 1'b1; pa[0] = 8'h05; pb[0] = 8'h03; po[0] = 3'd0;
    repeat (5) step();
    check("add_data", rsp_data, 8'h08);
    grants.delete();
    repeat (12) begin
      for (int i = 0; i < 2; i++) begin
        pv[i] = 1'b1; pa[i] = 8'h00; pb[i] = 8'h01; po[i] = 3'd1;
      end
      step();
    end
    repeat (6) step();
    check("rr_count", grants.size(), 6);
    foreach (grants[i]) check("rr_grant", grants[i], (i + 1) % 2);
    check("sub_wrap", rsp_data, 8'hFF);
    pv[2] = 1'b1; pa[2] = 8'h11; pb[2] = 8'h22; po[2] = 3'd0;
    rdy = 1'b0;
    repeat (8) step();
    check("stall_valid", rsp_valid, 1);
    check("stall_data", rsp_data, 8'h33);
    check("stall_id", rsp_id, 2);
    check("stall_busy", busy, 1);
    check("stall_ready", req_ready, 0);
    rdy = 1'b1;
    repeat (2) step();
    pv[1] = 1'b1; pa[1] = 8'hA5; pb[1] = 8'h00; po[1] = 3'd4;
    repeat (4) step();
    check("not_data", rsp_data, 8'h5A);
    pv[1] = 1'b1; pa[1] = 8'hF0; pb[1] = 8'h0F; po[1] = 3'd3;
    repeat (4) step();
    check("or_data", rsp_data, 8'hFF);
    pv[0] = 1'b1; pa[0] = 8'h12; pb[0] = 8'h34; po[0] = 3'd7;
    repeat (4) step();
    check("op7_data", rsp_data, 8'h00);
`ifdef ALU_SCHED_OPCHECK_EN
    check("op7_err", rsp_err, 1);
`else
    check("op7_err", rsp_err, 0);
`endif
    pv[0] = 1'b1; pa[0] = 8'h01; pb[0] = 8'h02; po[0] = 3'd0;
    rdy = 1'b0;
    repeat (4) step();
    check("mid_resp", rsp_valid, 1);
    do_reset();
    req_valid = 3'b011;
    #1;
    check("post_rst_first", req_ready, 3'b001);
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b1; pa[i] = 8'(i + 3); pb[i] = 8'h10; po[i] = 3'd2;
    end
    rdy = 1'b1;
    repeat (8) step();
    rnd = 1'b1;
    repeat (3000) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
